// File: rtl/hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : hazard_ctrl                                                   |
// | Purpose  : Pipeline hazard controller. Decodes load-use stalls, taken    |
// |            jump flushes and the multi-cycle stack (CALL/RET/RTI) memory  |
// |            sequence into PC / IF-ID / ID-EX write enables and flushes.   |
// | Ports    : clk, rst (async, active-low)                                  |
// |            id_src1/2, id_use1/2          - ID-stage operand reads        |
// |            ex_mr, ex_wb, ex_wb_addr      - ID/EX load destination        |
// |            ex_stack_pc, ex_stack_flags   - ID/EX stack operation bits    |
// |            ex_jmp_taken                  - EX resolved a taken redirect  |
// |            pc_en, if_id_en, id_ex_en     - buffer write enables          |
// |            if_id_flush, id_ex_flush      - load zero bubble              |
// |            mem_phase                     - stack word index (0 = idle)   |
// |            stall_cnt                     - saturating pc_en=0 counter    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  id_src1,
  input  logic [2:0]  id_src2,
  input  logic        id_use1,
  input  logic        id_use2,
  input  logic        ex_mr,
  input  logic        ex_wb,
  input  logic [2:0]  ex_wb_addr,
  input  logic        ex_stack_pc,
  input  logic        ex_stack_flags,
  input  logic        ex_jmp_taken,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic [1:0]  mem_phase,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    STK1 = 2'd1,
    STK2 = 2'd2,
    STK3 = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Decoded values before the reset override is applied.
  logic        pc_en_raw, if_id_en_raw, id_ex_en_raw;
  logic        if_id_flush_raw, id_ex_flush_raw;
  logic [1:0]  mem_phase_raw;
  logic        load_use;

  assign load_use = ex_mr & ex_wb &
                    ((id_use1 & (id_src1 == ex_wb_addr)) |
                     (id_use2 & (id_src2 == ex_wb_addr)));

  // Next-state and output decode. Priority inside RUN is
  // stack op > taken jump > load-use, so a jump coincident with a
  // load-use flushes the dependent instruction rather than stalling it.
  always_comb begin
    state_d         = RUN;
    pc_en_raw       = 1'b1;
    if_id_en_raw    = 1'b1;
    id_ex_en_raw    = 1'b1;
    if_id_flush_raw = 1'b0;
    id_ex_flush_raw = 1'b0;
    mem_phase_raw   = 2'd0;

    case (state_q)
      RUN: begin
        if (ex_stack_pc) begin
          mem_phase_raw = 2'd1;
          pc_en_raw     = 1'b0;
          if_id_en_raw  = 1'b0;
          id_ex_en_raw  = 1'b0;
          state_d       = STK1;
        end else if (ex_stack_flags) begin
          // Flags-only push/pop fits in a single memory cycle.
          mem_phase_raw = 2'd1;
        end else if (ex_jmp_taken) begin
          if_id_flush_raw = 1'b1;
          id_ex_flush_raw = 1'b1;
        end else if (load_use) begin
          pc_en_raw       = 1'b0;
          if_id_en_raw    = 1'b0;
          id_ex_flush_raw = 1'b1;
        end
      end

      STK1: begin
        mem_phase_raw = 2'd2;
        pc_en_raw     = 1'b0;
        if_id_en_raw  = 1'b0;
        id_ex_en_raw  = 1'b0;
        if (ex_stack_flags) begin
          state_d = STK2;
        end else begin
          // Final word: release the PC so the redirect target is fetched.
          pc_en_raw       = 1'b1;
          if_id_flush_raw = ex_jmp_taken;
          id_ex_flush_raw = ex_jmp_taken;
        end
      end

      STK2: begin
        mem_phase_raw   = 2'd3;
        pc_en_raw       = 1'b1;
        if_id_en_raw    = 1'b0;
        id_ex_en_raw    = 1'b0;
        if_id_flush_raw = ex_jmp_taken;
        id_ex_flush_raw = ex_jmp_taken;
      end

      default: begin
        // Illegal encoding: idle RUN outputs, recover to RUN.
        state_d = RUN;
      end
    endcase
  end

  // Counter uses the pre-override enable; while reset is low the
  // register is held at zero regardless.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_en_raw && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // While reset is held the pipeline free-runs with no stall or flush,
  // independent of whatever the hazard inputs are showing.
  assign pc_en       = rst ? pc_en_raw       : 1'b1;
  assign if_id_en    = rst ? if_id_en_raw    : 1'b1;
  assign id_ex_en    = rst ? id_ex_en_raw    : 1'b1;
  assign if_id_flush = rst ? if_id_flush_raw : 1'b0;
  assign id_ex_flush = rst ? id_ex_flush_raw : 1'b0;
  assign mem_phase   = rst ? mem_phase_raw   : 2'd0;
  assign stall_cnt   = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_hazard_ctrl                                                |
// | Purpose  : Directed self-checking bench for hazard_ctrl.                 |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [2:0]  id_src1, id_src2, ex_wb_addr;
  logic        id_use1, id_use2, ex_mr, ex_wb;
  logic        ex_stack_pc, ex_stack_flags, ex_jmp_taken;
  logic        pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush;
  logic [1:0]  mem_phase;
  logic [15:0] stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  hazard_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .id_src1        (id_src1),
    .id_src2        (id_src2),
    .id_use1        (id_use1),
    .id_use2        (id_use2),
    .ex_mr          (ex_mr),
    .ex_wb          (ex_wb),
    .ex_wb_addr     (ex_wb_addr),
    .ex_stack_pc    (ex_stack_pc),
    .ex_stack_flags (ex_stack_flags),
    .ex_jmp_taken   (ex_jmp_taken),
    .pc_en          (pc_en),
    .if_id_en       (if_id_en),
    .id_ex_en       (id_ex_en),
    .if_id_flush    (if_id_flush),
    .id_ex_flush    (id_ex_flush),
    .mem_phase      (mem_phase),
    .stall_cnt      (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge; inputs change here and
  // outputs are sampled a few ns later, well clear of either edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_src1 = 3'd0; id_src2 = 3'd0; ex_wb_addr = 3'd0;
    id_use1 = 1'b0; id_use2 = 1'b0; ex_mr = 1'b0; ex_wb = 1'b0;
    ex_stack_pc = 1'b0; ex_stack_flags = 1'b0; ex_jmp_taken = 1'b0;
  endtask

  // Compact output vector check: {pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, mem_phase}
  task automatic check_outs(input string tag, input logic [6:0] exp);
    #2;
    check_val(tag, {9'd0, pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, mem_phase},
              {9'd0, exp});
  endtask

  task automatic set_load_use();
    ex_mr = 1'b1; ex_wb = 1'b1; ex_wb_addr = 3'd3; id_src1 = 3'd3; id_use1 = 1'b1;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b0;
    set_load_use();
    ex_stack_pc = 1'b1;
    #3;
    // Reset held with hazard inputs active: RUN outputs, zero count.
    check_outs("reset_outs", 7'b111_00_00);
    check_val("reset_cnt", stall_cnt, 16'd0);
    step();
    clear_inputs();
    rst = 1'b1;

    // Load-use via src1
    step();
    set_load_use();
    check_outs("lu1_stall", 7'b001_01_00);
    check_val("lu1_cnt_before", stall_cnt, 16'd0);
    step();
    clear_inputs();
    check_outs("lu1_release", 7'b111_00_00);
    check_val("lu1_cnt_after", stall_cnt, 16'd1);

    // Load-use via src2
    step();
    ex_mr = 1'b1; ex_wb = 1'b1; ex_wb_addr = 3'd5; id_src2 = 3'd5; id_use2 = 1'b1; id_src1 = 3'd1; id_use1 = 1'b1;
    check_outs("lu2_stall", 7'b001_01_00);
    step();
    clear_inputs();
    check_val("lu2_cnt", stall_cnt, 16'd2);

    // Non-hazards
    set_load_use(); id_use1 = 1'b0;
    check_outs("nh_nouse", 7'b111_00_00);
    step();
    set_load_use(); ex_mr = 1'b0;
    check_outs("nh_nomr", 7'b111_00_00);
    step();
    set_load_use(); id_src1 = 3'd4;
    check_outs("nh_addr", 7'b111_00_00);
    step();
    set_load_use(); ex_wb = 1'b0;
    check_outs("nh_nowb", 7'b111_00_00);
    step();
    clear_inputs();
    check_val("nh_cnt", stall_cnt, 16'd2);

    // Jump + load-use: flush, no stall
    set_load_use(); ex_jmp_taken = 1'b1;
    check_outs("jmp_lu", 7'b111_11_00);
    step();
    clear_inputs();
    check_val("jmp_lu_cnt", stall_cnt, 16'd2);

    // CALL: stack_pc only, jump taken
    ex_stack_pc = 1'b1; ex_jmp_taken = 1'b1; set_load_use();
    check_outs("call_c1", 7'b000_00_01);
    step();
    #2;
    check_val("call_c2_pc_en", {15'd0, pc_en}, 16'd1);
    check_val("call_c2_flush", {14'd0, if_id_flush, id_ex_flush}, 16'b11);
    check_val("call_c2_phase", {14'd0, mem_phase}, 16'd2);
    step();
    clear_inputs();
    check_outs("call_done", 7'b111_00_00);
    check_val("call_cnt", stall_cnt, 16'd3);

    // RTI: stack_pc + flags, jump taken
    ex_stack_pc = 1'b1; ex_stack_flags = 1'b1; ex_jmp_taken = 1'b1;
    check_outs("rti_c1", 7'b000_00_01);
    step();
    check_outs("rti_c2", 7'b000_00_10);
    step();
    #2;
    check_val("rti_c3_pc_en", {15'd0, pc_en}, 16'd1);
    check_val("rti_c3_flush", {14'd0, if_id_flush, id_ex_flush}, 16'b11);
    check_val("rti_c3_phase", {14'd0, mem_phase}, 16'd3);
    step();
    clear_inputs();
    check_outs("rti_done", 7'b111_00_00);
    check_val("rti_cnt", stall_cnt, 16'd5);

    // RTI without jump: last cycle re-enables PC, no flush
    ex_stack_pc = 1'b1; ex_stack_flags = 1'b1;
    step();
    step();
    #2;
    check_val("rti_nj_pc_en", {15'd0, pc_en}, 16'd1);
    check_val("rti_nj_flush", {14'd0, if_id_flush, id_ex_flush}, 16'b00);
    step();
    clear_inputs();
    check_val("rti_nj_cnt", stall_cnt, 16'd7);

    // Flags only: single cycle, no stall
    ex_stack_flags = 1'b1;
    check_outs("flags_only", 7'b111_00_01);
    step();
    clear_inputs();
    check_outs("flags_only_done", 7'b111_00_00);
    check_val("flags_only_cnt", stall_cnt, 16'd7);

    // Reset pulsed during STK1
    ex_stack_pc = 1'b1; ex_jmp_taken = 1'b1;
    step();
    check_outs("rst_pre_stk1", 7'b100_11_10);
    rst = 1'b0;
    check_outs("rst_mid_outs", 7'b111_00_00);
    check_val("rst_mid_cnt", stall_cnt, 16'd0);
    step();
    clear_inputs();
    rst = 1'b1;
    step();
    check_outs("rst_after", 7'b111_00_00);
    check_val("rst_after_cnt", stall_cnt, 16'd0);

    // Saturation: hold a load-use for more than 2^16 cycles
    set_load_use();
    repeat (65540) @(posedge clk);
    #3;
    check_val("sat_cnt", stall_cnt, 16'hFFFF);
    check_val("sat_pc_en", {15'd0, pc_en}, 16'd0);
    step();
    clear_inputs();
    #2;
    check_val("sat_hold", stall_cnt, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have these ports: clk  input  1  pipeline clock, all state updates on its rising edge.
REQ-002 rst  input  1  asynchronous active-low reset.
REQ-003 id_src1, id_src2  input  3 each  register addresses read by the instruction in ID.
REQ-004 id_use1, id_use2  input  1 each  ID instruction actually reads src1 / src2.
REQ-005 ex_mr, ex_wb  input  1 each  MR and WB control bits of the ID/EX buffer.
REQ-006 ex_wb_addr  input  3  WB_Address of the ID/EX buffer.
REQ-007 ex_stack_pc, ex_stack_flags  input  1 each  Stack_PC and Stack_Flags bits of the ID/EX buffer.
REQ-008 ex_jmp_taken  input  1  EX resolved a taken jump/call/return target this cycle.
REQ-009 pc_en, if_id_en, id_ex_en  output  1 each  write enables for PC, IF/ID and ID/EX buffers.
REQ-010 if_id_flush, id_ex_flush  output  1 each  load a zero bubble instead of DataIn.
REQ-011 mem_phase  output  2  stack word index for the memory stage: 0 idle, 1..3 word being transferred.
REQ-012 stall_cnt  output  16  saturating count of cycles with pc_en=0.

Function
REQ-013 States SHALL be RUN, STK1, STK2, STK3; state register resets to RUN.
REQ-014 In RUN with no hazard: pc_en=if_id_en=id_ex_en=1, both flushes 0, mem_phase=0.
REQ-015 Load-use hazard SHALL be ex_mr & ex_wb & ((id_use1 & id_src1==ex_wb_addr) | (id_use2 & id_src2==ex_wb_addr)).
REQ-016 On load-use in RUN: pc_en=0, if_id_en=0, id_ex_flush=1 for exactly one cycle; state stays RUN.
REQ-017 On ex_jmp_taken in RUN (no stack op): if_id_flush=1, id_ex_flush=1, pc_en=1 for one cycle.
REQ-018 Stack op: ex_stack_pc=1 in RUN SHALL transition to STK1 next edge; current cycle mem_phase=1, pc_en=if_id_en=id_ex_en=0.
REQ-019 STK1 SHALL output mem_phase=2, all enables 0, then go to STK2 if ex_stack_flags else RUN.
REQ-020 STK2 SHALL output mem_phase=3, all enables 0, then go to RUN.
REQ-021 STK3 is unreachable; any illegal state SHALL return to RUN next edge with RUN outputs.
REQ-022 Last cycle of a stack sequence (STK1 without flags, STK2 with flags) SHALL also assert if_id_flush and id_ex_flush when ex_jmp_taken=1, and re-enable pc_en.
REQ-023 Total stack latency: 2 cycles for ex_stack_pc only, 3 cycles with ex_stack_flags; ex_stack_flags without ex_stack_pc SHALL be treated as 1 cycle, mem_phase=1, no stall.
REQ-024 Priority within a cycle: stack sequence > ex_jmp_taken > load-use; load-use coincident with taken jump SHALL flush, not stall.
REQ-025 During STK states, ID/EX inputs are frozen by id_ex_en=0; hazard_ctrl SHALL ignore load-use and new stack requests.
REQ-026 stall_cnt SHALL increment by 1 each cycle pc_en=0 and saturate at 16'hFFFF.
REQ-027 All outputs except stall_cnt SHALL be combinational decodes of state and inputs; no output register latency.

Reset
REQ-028 rst=0 SHALL asynchronously force state RUN, stall_cnt=0; while rst=0 outputs SHALL be pc_en=if_id_en=id_ex_en=1, flushes 0, mem_phase=0.
REQ-029 Reset asserted mid stack sequence SHALL abort it; first cycle after release is RUN with no residual stall.

Verification
REQ-030 Load-use: ex_mr=1, ex_wb=1, ex_wb_addr=3, id_src1=3, id_use1=1 -> one cycle pc_en=0, if_id_en=0, id_ex_flush=1, stall_cnt 0->1; next cycle all enables 1.
REQ-031 Non-hazard: same but id_use1=0 or ex_mr=0 -> no stall, stall_cnt unchanged.
REQ-032 CALL: ex_stack_pc=1, ex_stack_flags=0, ex_jmp_taken=1 -> mem_phase 1,2 on two cycles, enables 0 then pc_en=1 with both flushes on cycle 2, stall_cnt +1.
REQ-033 RTI: ex_stack_pc=1, ex_stack_flags=1 -> mem_phase 1,2,3; enables 0 for two cycles; flush on cycle 3 when ex_jmp_taken=1.
REQ-034 Jump + load-use same cycle -> both flushes 1, pc_en=1, no stall.
REQ-035 rst pulsed low during STK1 -> outputs immediately return to RUN values, stall_cnt=0, mem_phase=0.
